// File: rtl/fpu_issue_sched.sv
// In-order issue scheduler for the multi-cycle FPU datapath.
// Stalls an FPU op until its source and destination registers are free in the
// scoreboard and the single writeback port is free in its result cycle.
// Announces each writeback to the FP register file in the correct cycle.
//
// Func encoding:
//   0 ADD, 1 SUB, 2 MUL, 3 INV, 4 SQRT, 5 ABS, 6 NEG,
//   7 EQ, 8 LT, 9 LE, 10 FTOI, 11 ITOF. Every other code is illegal.
//
// Reservation slot k, read in cycle c, marks a writeback due in cycle c+k.
// The top slot is never written: a result due MAX_LAT cycles out can only come
// from an op issued in the current cycle, and that op lands one slot lower
// after the shift.
module fpu_issue_sched #(
    parameter int unsigned LAT_ADD    = 2,
    parameter int unsigned LAT_MUL    = 2,
    parameter int unsigned LAT_INV    = 4,
    parameter int unsigned LAT_SQRT   = 4,
    parameter int unsigned LAT_CONV   = 2,
    parameter int unsigned LAT_SIMPLE = 1,
    parameter int unsigned MAX_LAT    = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       issue_valid,
    output logic       issue_ready,
    input  logic [5:0] issue_func,
    input  logic [4:0] issue_rd,
    input  logic [4:0] issue_rs,
    input  logic [4:0] issue_rt,
    output logic       fpu_start,
    output logic [5:0] fpu_func,
    output logic       wb_valid,
    output logic [4:0] wb_rd,
    output logic       illegal_op,
    output logic       idle
);

    localparam logic [5:0] FuncAdd  = 6'd0;
    localparam logic [5:0] FuncSub  = 6'd1;
    localparam logic [5:0] FuncMul  = 6'd2;
    localparam logic [5:0] FuncInv  = 6'd3;
    localparam logic [5:0] FuncSqrt = 6'd4;
    localparam logic [5:0] FuncAbs  = 6'd5;
    localparam logic [5:0] FuncNeg  = 6'd6;
    localparam logic [5:0] FuncEq   = 6'd7;
    localparam logic [5:0] FuncLt   = 6'd8;
    localparam logic [5:0] FuncLe   = 6'd9;
    localparam logic [5:0] FuncFtoi = 6'd10;
    localparam logic [5:0] FuncItof = 6'd11;

    // Scoreboard and reservation state
    logic [31:0]              busy_q, busy_d;
    logic [MAX_LAT:1]         res_v_q, res_v_d;
    logic [MAX_LAT:1][4:0]    res_rd_q, res_rd_d;
    logic                     wb_valid_q, wb_valid_d;
    logic [4:0]               wb_rd_q, wb_rd_d;
    logic                     illegal_q, illegal_d;

    // Decode results
    logic                     legal;
    logic                     binary;
    int unsigned              lat;
    logic                     slot_taken;
    logic                     hazard;
    logic                     handshake;
    logic                     start;

    // Classify the presented func: legality, operand count and latency.
    always_comb begin
        legal  = 1'b1;
        binary = 1'b0;
        lat    = 1;
        case (issue_func)
            FuncAdd, FuncSub: begin
                lat    = LAT_ADD;
                binary = 1'b1;
            end
            FuncMul: begin
                lat    = LAT_MUL;
                binary = 1'b1;
            end
            FuncInv:  lat = LAT_INV;
            FuncSqrt: lat = LAT_SQRT;
            FuncAbs, FuncNeg: lat = LAT_SIMPLE;
            FuncEq, FuncLt, FuncLe: begin
                lat    = LAT_SIMPLE;
                binary = 1'b1;
            end
            FuncFtoi, FuncItof: lat = LAT_CONV;
            default: legal = 1'b0;
        endcase
    end

    // Look up whether the writeback cycle of this op is already reserved.
    always_comb begin
        slot_taken = 1'b0;
        for (int unsigned k = 1; k <= MAX_LAT; k++) begin
            if (k == lat) begin
                slot_taken = res_v_q[k];
            end
        end
    end

    // Issue decision. Illegal ops are consumed regardless of hazards.
    always_comb begin
        hazard = busy_q[issue_rs]
               | (binary & busy_q[issue_rt])
               | busy_q[issue_rd]
               | slot_taken;
        issue_ready = !reset && (!legal || !hazard);
        handshake   = issue_valid && issue_ready;
        start       = handshake && legal;
        fpu_start   = start;
        fpu_func    = issue_func;
    end

    // Next-state: shift reservations, retire writebacks, record new issues.
    always_comb begin
        busy_d = busy_q;
        // A retiring register and a newly issued rd never coincide (WAW check),
        // so the order of these two updates does not matter.
        if (wb_valid_q) begin
            busy_d[wb_rd_q] = 1'b0;
        end
        if (start) begin
            busy_d[issue_rd] = 1'b1;
        end

        wb_valid_d = res_v_q[1];
        wb_rd_d    = res_rd_q[1];
        res_v_d    = '0;
        res_rd_d   = '0;
        for (int unsigned k = 1; k < MAX_LAT; k++) begin
            res_v_d[k]  = res_v_q[k + 1];
            res_rd_d[k] = res_rd_q[k + 1];
        end

        if (start) begin
            if (lat == 1) begin
                // Single-cycle op bypasses the shift register straight to wb.
                wb_valid_d = 1'b1;
                wb_rd_d    = issue_rd;
            end else begin
                for (int unsigned k = 1; k < MAX_LAT; k++) begin
                    if (k + 1 == lat) begin
                        res_v_d[k]  = 1'b1;
                        res_rd_d[k] = issue_rd;
                    end
                end
            end
        end

        illegal_d = handshake && !legal;
    end

    // State registers with synchronous reset; reset drops all in-flight results.
    always_ff @(posedge clk) begin
        if (reset) begin
            busy_q     <= '0;
            res_v_q    <= '0;
            res_rd_q   <= '0;
            wb_valid_q <= 1'b0;
            wb_rd_q    <= '0;
            illegal_q  <= 1'b0;
        end else begin
            busy_q     <= busy_d;
            res_v_q    <= res_v_d;
            res_rd_q   <= res_rd_d;
            wb_valid_q <= wb_valid_d;
            wb_rd_q    <= wb_rd_d;
            illegal_q  <= illegal_d;
        end
    end

    // Registered status outputs.
    always_comb begin
        wb_valid   = wb_valid_q;
        wb_rd      = wb_rd_q;
        illegal_op = illegal_q;
        idle       = (busy_q == '0) && (res_v_q == '0);
    end

endmodule

// File: doc/fpu_issue_sched.md
Name: fpu_issue_sched

Overview:
- In-order issue scheduler for the multi-cycle FPU datapath (OP_FPU instructions, selected by 6-bit func).
- Between decode and the FPU. Accepts at most one FPU op per cycle and starts it on the datapath only when all three conditions hold: its source and destination FP registers are free (scoreboard), and the single FP writeback port is free in its result cycle (reservation shift register).
- Announces each writeback to the register file in the correct cycle.

Parameters:
- LAT_ADD, 2, latency of FPU_ADD/FPU_SUB.
- LAT_MUL, 2, latency of FPU_MUL.
- LAT_INV, 4, latency of FPU_INV.
- LAT_SQRT, 4, latency of FPU_SQRT.
- LAT_CONV, 2, latency of FPU_FTOI/FPU_ITOF.
- LAT_SIMPLE, 1, latency of FPU_ABS/FPU_NEG/FPU_EQ/FPU_LT/FPU_LE.
- MAX_LAT, 8, reservation depth; every LAT_* must be in 1..MAX_LAT.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- issue_valid  in  1  decode presents an FPU op
- issue_ready  out  1  op accepted this cycle (handshake = valid && ready)
- issue_func  in  6  FPU func code
- issue_rd  in  5  destination FP register
- issue_rs  in  5  source FP register 1
- issue_rt  in  5  source FP register 2 (read only by binary ops)
- fpu_start  out  1  start pulse to FPU datapath
- fpu_func  out  6  func to datapath (= issue_func)
- wb_valid  out  1  FPU result is written this cycle
- wb_rd  out  5  destination of that result
- illegal_op  out  1  one-cycle pulse: an unsupported func was consumed
- idle  out  1  no op in flight

Behaviour:
Interface and op classes:
- One clock domain (clk). Reset is synchronous and active-high (reset).
- Binary ops read rs and rt: ADD, SUB, MUL, EQ, LT, LE.
- Unary ops read rs only: INV, SQRT, ABS, NEG, FTOI, ITOF.
- Every legal op writes rd.
- Any other func is illegal.

State:
- busy[31:0] scoreboard.
- Reservation register res_v[1..MAX_LAT] with res_rd[1..MAX_LAT].
- Each cycle the reservation register shifts one slot toward slot 1.
- wb_valid and wb_rd are registered outputs taken from slot 1 as it shifts out.

Issue rules (combinational):
- Let L be the latency of the op and t the issue cycle.
- Hazard condition:
  - busy[rs]; or
  - busy[rt] for a binary op; or
  - busy[rd] (WAW); or
  - a result already reserved for cycle t+L.
- Legal op: issue_ready = !reset && !hazard.
- Illegal op: issue_ready = !reset, regardless of hazards.
- fpu_start = issue_valid && issue_ready && legal. fpu_func = issue_func.
- issue_ready depends on the issue_* inputs; decode must hold them stable while issue_valid is high.

On a legal handshake in cycle t:
- busy[rd] is set from cycle t+1.
- wb_valid=1 with wb_rd=rd in exactly cycle t+L.
- busy[rd] is cleared at the end of cycle t+L; it reads 0 in cycle t+L+1.
- No bypass: a dependent op issues at the earliest in cycle t+L+1.

Simultaneous events:
- Issue and writeback in the same cycle are both honoured.
- A clear and a set on the same register cannot occur (the WAW check prevents it).

Illegal handshake in cycle t:
- illegal_op=1 in cycle t+1 only.
- No fpu_start, no scoreboard or reservation change.

Other outputs:
- idle = (busy==0) && no res_v set.
- Ops of different latencies may complete out of order. Writeback never collides; a colliding issue is stalled, not dropped.

Reset:
- Overrides everything, including reset asserted mid-flight.
- Clears busy and res_v. In-flight results are discarded and are not written back.
- wb_valid=0, wb_rd=0, illegal_op=0, idle=1.
- issue_ready=0 and fpu_start=0 while reset is high.

Test Plan:
1. ADD rd=3 issued at t=10 → fpu_start@10, wb_valid/wb_rd=3@12, busy[3] clear @13.
2. SQRT rd=5 @t, then MUL rs=5 presented @t+1 → issue_ready=0 through t+4, issue at t+5, wb rd of MUL at t+7.
3. INV rd=1 @0, then ABS rd=2 presented @3 → wants wb @4, collides with INV → stall; issue @4, wb rd=2 @5; wb rd=1 @4 unaffected.
4. WAW: MUL rd=7 @0, then NEG rd=7 @1 → ready=0 until cycle 3; single wb of rd=7 @2, NEG wb @4.
5. func=6'b111111 with busy registers pending → issue_ready=1, fpu_start=0, illegal_op pulse next cycle, busy unchanged.
6. Reset asserted at cycle after SQRT issue → wb_valid stays 0 for 6 cycles after reset release, idle=1, busy=0.
